// File: rtl/vga_fb_arbiter.sv
// Frame-buffer slot arbiter: keeps a pixel prefetch FIFO filled for VGA scanout and hands
// spare RAM slots to host writes. Defining FB_STARVE_GUARD_EN adds a host starvation guard.
module vga_fb_arbiter #(
   parameter int ADDR_W       = 19,
   parameter int DATA_W       = 24,
   parameter int FRAME_PIXELS = 307200,
   parameter int FIFO_DEPTH   = 8,
   parameter int LOW_MARK     = 4,
   parameter int MAX_WAIT     = 16
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic              FRAME_START,
   input  logic              PIX_RD,
   output logic [DATA_W-1:0] PIX_DATA,
   output logic              UNDERFLOW,
   input  logic              WR_REQ,
   input  logic [ADDR_W-1:0] WR_ADDR,
   input  logic [DATA_W-1:0] WR_DATA,
   output logic              WR_ACK,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   output logic              MEM_WE,
   input  logic [DATA_W-1:0] MEM_RDATA
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  LOW_C     = CNT_W'(LOW_MARK);
   localparam logic [ADDR_W:0]   FRAME_C   = (ADDR_W+1)'(FRAME_PIXELS);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

   if ((1 << PTR_W) != FIFO_DEPTH || LOW_MARK > FIFO_DEPTH || MAX_WAIT < 1) begin : g_bad_params
      $error("vga_fb_arbiter: FIFO_DEPTH must be a power of two, LOW_MARK <= FIFO_DEPTH, MAX_WAIT >= 1");
   end

   typedef enum logic [1:0] {
      SLOT_IDLE  = 2'd0,
      SLOT_READ  = 2'd1,
      SLOT_WRITE = 2'd2
   } slot_t;

   slot_t              slot;
   logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               rd_inflight;
   logic [ADDR_W-1:0]  scan_addr;
   logic [CNT_W-1:0]   level;
   logic               do_push;
   logic               do_pop;
   logic               wr_in_range;

   // Level counts the read already on the bus, so a read is never issued without a free entry.
   assign level       = count + CNT_W'(rd_inflight);
   assign do_push     = rd_inflight && !FRAME_START;
   assign do_pop      = PIX_RD && !FRAME_START && (count != '0);
   assign wr_in_range = ({1'b0, WR_ADDR} < FRAME_C);

`ifdef FB_STARVE_GUARD_EN
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] wait_cnt;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         wait_cnt <= '0;
      end else if (!WR_REQ || slot == SLOT_WRITE) begin
         wait_cnt <= '0;
      end else if (wait_cnt != MAX_WAIT_C) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end
`endif

   // Host handshake: WR_REQ with WR_ADDR/WR_DATA is consumed at the edge that grants the slot;
   // WR_ACK is high for the cycle after that edge, and whatever is on WR_* at the next edge
   // is a new request.
   always_comb begin
      slot = SLOT_IDLE;
      if (FRAME_START) begin
         slot = SLOT_IDLE;
      end
`ifdef FB_STARVE_GUARD_EN
      else if (WR_REQ && wait_cnt == MAX_WAIT_C) begin
         slot = SLOT_WRITE;
      end
`endif
      else if (level < LOW_C) begin
         slot = SLOT_READ;
      end else if (WR_REQ) begin
         slot = SLOT_WRITE;
      end else if (level < DEPTH_C) begin
         slot = SLOT_READ;
      end
   end

   // Storage needs no reset: occupancy is tracked by count and the pointers.
   always_ff @(posedge CLOCK_50) begin
      if (do_push) begin
         fifo_mem[wr_ptr] <= MEM_RDATA;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         MEM_ADDR    <= '0;
         MEM_WDATA   <= '0;
         MEM_WE      <= 1'b0;
         WR_ACK      <= 1'b0;
         scan_addr   <= '0;
         rd_inflight <= 1'b0;
      end else begin
         WR_ACK      <= (slot == SLOT_WRITE);
         MEM_WE      <= (slot == SLOT_WRITE) && wr_in_range;
         rd_inflight <= (slot == SLOT_READ);
         if (slot == SLOT_READ) begin
            MEM_ADDR  <= scan_addr;
            scan_addr <= (scan_addr == LAST_ADDR) ? '0 : scan_addr + 1'b1;
         end else if (slot == SLOT_WRITE && wr_in_range) begin
            MEM_ADDR  <= WR_ADDR;
            MEM_WDATA <= WR_DATA;
         end
         if (FRAME_START) begin
            scan_addr <= '0;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         PIX_DATA  <= '0;
         UNDERFLOW <= 1'b0;
      end else if (FRAME_START) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         UNDERFLOW <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            PIX_DATA <= fifo_mem[rd_ptr];
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
         if (PIX_RD && count == '0) begin
            UNDERFLOW <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a data=address RAM model and a shortened frame
// (FRAME_PIXELS = 700) so the scan-address wrap is reachable.
module tb_vga_fb_arbiter;

   localparam int ADDR_W = 19;
   localparam int DATA_W = 24;
   localparam int FP     = 700;

   logic              clock_50;
   logic              reset_n;
   logic              frame_start;
   logic              pix_rd;
   logic [DATA_W-1:0] pix_data;
   logic              underflow;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_we;
   logic [DATA_W-1:0] mem_rdata;

   int vectors = 0;
   int miscompares = 0;
   logic [DATA_W-1:0] exp_q[$];

   vga_fb_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .FRAME_PIXELS (FP),
      .FIFO_DEPTH   (8),
      .LOW_MARK     (4),
      .MAX_WAIT     (16)
   ) dut (
      .CLOCK_50    (clock_50),
      .RESET_N     (reset_n),
      .FRAME_START (frame_start),
      .PIX_RD      (pix_rd),
      .PIX_DATA    (pix_data),
      .UNDERFLOW   (underflow),
      .WR_REQ      (wr_req),
      .WR_ADDR     (wr_addr),
      .WR_DATA     (wr_data),
      .WR_ACK      (wr_ack),
      .MEM_ADDR    (mem_addr),
      .MEM_WDATA   (mem_wdata),
      .MEM_WE      (mem_we),
      .MEM_RDATA   (mem_rdata)
   );

   // RAM preloaded with data = address; registered MEM_ADDR makes this a one-cycle read.
   assign mem_rdata = DATA_W'(mem_addr);

   initial clock_50 = 1'b0;
   always #10 clock_50 = ~clock_50;

   initial begin
      #(20 * 20000);
      $display("FAIL watchdog: simulation exceeded 20000 cycles");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock_50);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pix_data"}, 32'(pix_data), 32'h0);
      check({tag, "_underflow"}, 32'(underflow), 32'h0);
      check({tag, "_wr_ack"}, 32'(wr_ack), 32'h0);
      check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
      check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
   endtask

   task automatic pulse_frame_start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   initial begin
      int underflow_at;
      int ack_at;
      int ack_cnt;

      reset_n     = 1'b0;
      frame_start = 1'b0;
      pix_rd      = 1'b0;
      wr_req      = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;

      // Reset state
      tick();
      tick();
      check_reset_outputs("reset");

      // Release with FRAME_START: 8 reads at 0..7 on consecutive cycles, then idle
      reset_n = 1'b1;
      pulse_frame_start();
      for (int k = 0; k < 8; k++) begin
         tick();
         check($sformatf("fill_addr_%0d", k), 32'(mem_addr), 32'(k));
         check($sformatf("fill_we_%0d", k), 32'(mem_we), 32'h0);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("full_idle_addr_%0d", k), 32'(mem_addr), 32'd7);
      end
      check("fill_underflow", 32'(underflow), 32'h0);

      // Host write while the FIFO is full: one cycle of MEM_WE with WR_ACK
      wr_req  = 1'b1;
      wr_addr = 19'h100;
      wr_data = 24'hFF0000;
      tick();
      check("wr_ack", 32'(wr_ack), 32'h1);
      check("wr_we", 32'(mem_we), 32'h1);
      check("wr_addr", 32'(mem_addr), 32'h100);
      check("wr_wdata", 32'(mem_wdata), 32'hFF0000);
      wr_req = 1'b0;
      tick();
      check("wr_ack_single", 32'(wr_ack), 32'h0);
      check("wr_we_single", 32'(mem_we), 32'h0);

      // Out-of-frame address is acknowledged but dropped; last valid address is written
      wr_req  = 1'b1;
      wr_addr = 19'(FP);
      wr_data = 24'h123456;
      tick();
      check("drop_ack", 32'(wr_ack), 32'h1);
      check("drop_we", 32'(mem_we), 32'h0);
      wr_addr = 19'(FP - 1);
      wr_data = 24'h00ABCD;
      tick();
      check("last_ack", 32'(wr_ack), 32'h1);
      check("last_we", 32'(mem_we), 32'h1);
      check("last_addr", 32'(mem_addr), 32'(FP - 1));
      check("last_wdata", 32'(mem_wdata), 32'h00ABCD);

      // Back-to-back writes at full FIFO: ACK every cycle
      for (int k = 0; k < 3; k++) begin
         wr_addr = 19'(32'h200 + k);
         wr_data = 24'(32'h010101 * (k + 1));
         tick();
         check($sformatf("b2b_ack_%0d", k), 32'(wr_ack), 32'h1);
         check($sformatf("b2b_addr_%0d", k), 32'(mem_addr), 32'h200 + 32'(k));
         check($sformatf("b2b_wdata_%0d", k), 32'(mem_wdata), 32'h010101 * 32'(k + 1));
      end
      wr_req = 1'b0;
      tick();
      check("b2b_end_ack", 32'(wr_ack), 32'h0);

      // Scanout: pop every 2 cycles from F+3, through the frame wrap at FP-1 -> 0
      for (int i = 0; i < 720; i++) exp_q.push_back(DATA_W'(i % FP));
      pulse_frame_start();
      tick();
      tick();
      for (int i = 0; i < 720; i++) begin
         logic [DATA_W-1:0] exp_pix;
         pix_rd = 1'b1;
         tick();
         pix_rd = 1'b0;
         exp_pix = exp_q.pop_front();
         check($sformatf("scan_pix_%0d", i), 32'(pix_data), 32'(exp_pix));
         tick();
      end
      check("scan_underflow", 32'(underflow), 32'h0);

      // FRAME_START with simultaneous PIX_RD: pop ignored, FIFO flushed
      frame_start = 1'b1;
      pix_rd      = 1'b1;
      tick();
      frame_start = 1'b0;
      check("fs_pop_ignored", 32'(pix_data), 32'd19);
      check("fs_underflow", 32'(underflow), 32'h0);
      tick();
      check("fs_first_read", 32'(mem_addr), 32'h0);
      check("fs_flush_pix", 32'(pix_data), 32'd19);
      check("fs_flush_underflow", 32'(underflow), 32'h1);
      pix_rd = 1'b0;
      tick();
      pix_rd = 1'b1;
      tick();
      pix_rd = 1'b0;
      check("fs_first_pix", 32'(pix_data), 32'h0);
      check("underflow_sticky", 32'(underflow), 32'h1);
      pulse_frame_start();
      check("underflow_cleared", 32'(underflow), 32'h0);

      // PIX_RD every cycle with continuous host request
      wr_req  = 1'b1;
      wr_addr = 19'h50;
      wr_data = 24'hAAAAAA;
      pix_rd  = 1'b1;
      underflow_at = 0;
      ack_at       = 0;
      ack_cnt      = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (underflow && underflow_at == 0) underflow_at = i;
         if (wr_ack) begin
            ack_cnt++;
            if (ack_at == 0) ack_at = i;
            wr_req = 1'b0;
         end
      end
      pix_rd = 1'b0;
      wr_req = 1'b0;
      check("starve_underflow_within_12", 32'(underflow_at >= 1 && underflow_at <= 12), 32'h1);
`ifdef FB_STARVE_GUARD_EN
      check("guard_ack_within_17", 32'(ack_at >= 1 && ack_at <= 17), 32'h1);
      check("guard_ack_count", 32'(ack_cnt), 32'h1);
`else
      check("starve_no_ack", 32'(ack_cnt), 32'h0);
`endif

      // Asynchronous reset mid-line with reads in flight
      pulse_frame_start();
      pix_rd = 1'b1;
      tick();
      pix_rd = 1'b0;
      tick();
      pix_rd = 1'b1;
      tick();
      tick();
      pix_rd = 1'b0;
      check("pre_reset_addr", 32'(mem_addr), 32'd3);
      check("pre_reset_pix", 32'(pix_data), 32'd1);
      check("pre_reset_underflow", 32'(underflow), 32'h1);
      #5;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      tick();
      tick();
      reset_n = 1'b1;
      pulse_frame_start();
      tick();
      check("post_reset_first_read", 32'(mem_addr), 32'h0);
      check("post_reset_we", 32'(mem_we), 32'h0);
      tick();
      check("post_reset_second_read", 32'(mem_addr), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
